adder_arbiter: RTL

Two-requester controller that shares one combinational 14-bit `Adder` datapath. It accepts add requests over valid/ready handshakes and grants them round-robin. It sequences the selected operands through the adder, registers the 15-bit result, and returns it with the requester ID over a valid/ready response channel. It sits between the calculator front-end units and the single `Adder` instance, so neither unit drives the adder directly.

---
 rtl/adder_arbiter_if.sv | 46 ++++
 rtl/adder_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
// Bundle of request, adder and response signals between the calculator
// front-end units, the arbiter and the shared Adder instance.
interface adder_arbiter_if #(
    parameter int WIDTH = 14
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_data;
    logic             rsp_id;
    logic             busy;

    // Arbiter side: accepts requests, drives the adder, produces responses.
    modport slave (
        input  req_valid, req0_a, req0_b, req0_cin, req1_a, req1_b, req1_cin,
        output req_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_data, rsp_id, busy,
        input  rsp_ready
    );

    // Environment side: requesters, the Adder instance and the consumer.
    modport master (
        output req_valid, req0_a, req0_b, req0_cin, req1_a, req1_b, req1_cin,
        input  req_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_data, rsp_id, busy,
        output rsp_ready
    );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a single shared combinational
// adder. One add is in flight at a time: accept, evaluate, respond.
//
// state | meaning
// IDLE  | no transaction; req_ready offered to the round-robin winner
// EXEC  | operand registers drive the adder; sum captured at end of cycle
// RESP  | result held on rsp_data/rsp_id until the consumer takes it
module adder_arbiter #(
    parameter int WIDTH = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             prio;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH:0]   rsp_data_q;
    logic             rsp_id_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic [1:0]       grant;

    // Round-robin grant: a lone requester always wins, a tie goes to prio.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.req_ready = grant;

    // The adder only ever sees registered operands, so its path starts at a
    // flop and ends at the rsp_data flop.
    assign bus.add_a     = op_a;
    assign bus.add_b     = op_b;
    assign bus.add_cin   = op_cin;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        op_a     <= bus.req0_a;
                        op_b     <= bus.req0_b;
                        op_cin   <= bus.req0_cin;
                        rsp_id_q <= 1'b0;
                        prio     <= 1'b1;
                        state    <= EXEC;
                        busy_q   <= 1'b1;
                    end else if (grant[1]) begin
                        op_a     <= bus.req1_a;
                        op_b     <= bus.req1_b;
                        op_cin   <= bus.req1_cin;
                        rsp_id_q <= 1'b1;
                        prio     <= 1'b0;
                        state    <= EXEC;
                        busy_q   <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= {bus.add_cout, bus.add_sum};
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
